// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder/subtractor.
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } adder_op_e;

  // Bits rippled per pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational ripple-carry slice of CHUNK bits; also exposes the carry into
// its MSB so the top can form signed overflow on the final chunk.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  // NOTE: combinational logic uses blocking assignments so each bit sees the
  // carry computed by the previous loop iteration.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit carry slice per stage,
// operands skewed forward, partial sums deskewed, single global stall.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic             out_ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_ripple_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic adv;
  logic is_sub;

  // Stage inputs (combinational) and stage registers.
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] s_in   [STAGES];
  logic             c_in   [STAGES];
  logic             v_in   [STAGES];
  logic [WIDTH-1:0] s_next [STAGES];

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;

  logic [CHUNK-1:0] s_chunk [STAGES];
  logic             co      [STAGES];
  logic             c_msb   [STAGES];

  // Whole pipe moves together; a full output slot blocks everything behind it.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign is_sub   = (adder_op_e'(in_op) == OP_SUB);

  always_comb begin
    a_in[0] = in_a;
    b_in[0] = is_sub ? ~in_b : in_b;
    c_in[0] = is_sub | in_ci;
    v_in[0] = in_valid;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (a_in[k][k*CHUNK +: CHUNK]),
      .b        (b_in[k][k*CHUNK +: CHUNK]),
      .ci       (c_in[k]),
      .s        (s_chunk[k]),
      .co       (co[k]),
      .c_msb_in (c_msb[k])
    );
  end

  // Lower chunks ride along from earlier stages; this stage fills in its own.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_next[k]                   = s_in[k];
      s_next[k][k*CHUNK +: CHUNK] = s_chunk[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the datapath registers
  // are reset too because out_sum/out_co/out_ovf must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_next[k];
        c_q[k] <= co[k];
        v_q[k] <= v_in[k];
      end
      ovf_q <= co[STAGES-1] ^ c_msb[STAGES-1];
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_sum   = s_q[STAGES-1];
  assign out_co    = c_q[STAGES-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed and random stream bench for pipelined_ripple_adder at 16/4, 12/3 and 8/1.
module tb_pipelined_ripple_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        op;
    logic [15:0] sum;
    logic        co;
    logic        ovf;
  } beat_t;

  localparam int W_D [3] = '{16, 12, 8};
  localparam int S_D [3] = '{4, 3, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        ivld [3];
  logic        ordy [3];
  logic [15:0] a_i  [3];
  logic [15:0] b_i  [3];
  logic        ci_i [3];
  logic        op_i [3];

  logic        irdy16, irdy12, irdy8, ov16, ov12, ov8;
  logic        co16, co12, co8, ovf16, ovf12, ovf8;
  logic [15:0] sum16;
  logic [11:0] sum12;
  logic [7:0]  sum8;

  logic        irdy_o [3];
  logic        ov_o   [3];
  logic        co_o   [3];
  logic        ovf_o  [3];
  logic [15:0] sum_o  [3];

  assign irdy_o[0] = irdy16; assign irdy_o[1] = irdy12; assign irdy_o[2] = irdy8;
  assign ov_o[0]   = ov16;   assign ov_o[1]   = ov12;   assign ov_o[2]   = ov8;
  assign co_o[0]   = co16;   assign co_o[1]   = co12;   assign co_o[2]   = co8;
  assign ovf_o[0]  = ovf16;  assign ovf_o[1]  = ovf12;  assign ovf_o[2]  = ovf8;
  assign sum_o[0]  = sum16;
  assign sum_o[1]  = {4'h0, sum12};
  assign sum_o[2]  = {8'h00, sum8};

  pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[0]), .in_ready(irdy16),
    .in_a(a_i[0]), .in_b(b_i[0]), .in_ci(ci_i[0]), .in_op(op_i[0]),
    .out_valid(ov16), .out_ready(ordy[0]), .out_sum(sum16), .out_co(co16), .out_ovf(ovf16)
  );

  pipelined_ripple_adder #(.WIDTH(12), .STAGES(3)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[1]), .in_ready(irdy12),
    .in_a(a_i[1][11:0]), .in_b(b_i[1][11:0]), .in_ci(ci_i[1]), .in_op(op_i[1]),
    .out_valid(ov12), .out_ready(ordy[1]), .out_sum(sum12), .out_co(co12), .out_ovf(ovf12)
  );

  pipelined_ripple_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[2]), .in_ready(irdy8),
    .in_a(a_i[2][7:0]), .in_b(b_i[2][7:0]), .in_ci(ci_i[2]), .in_op(op_i[2]),
    .out_valid(ov8), .out_ready(ordy[2]), .out_sum(sum8), .out_co(co8), .out_ovf(ovf8)
  );

  // Pending input beats, model pipeline contents and bookkeeping per DUT.
  beat_t txq  [3][$];
  beat_t pipe [3][4];
  logic  pv   [3][4];
  int    popped [3];
  int    pushed [3];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on plain integers: {ovf, co, sum}.
  function automatic logic [17:0] ref_result(input int w, input logic [15:0] a,
                                             input logic [15:0] b, input logic ci,
                                             input logic op);
    logic [31:0] mask, aa, bb, full, sum;
    logic        co, ovf;
    mask = (32'd1 << w) - 32'd1;
    aa   = {16'h0, a} & mask;
    bb   = (op ? ~{16'h0, b} : {16'h0, b}) & mask;
    full = aa + bb + (op ? 32'd1 : {31'd0, ci});
    sum  = full & mask;
    co   = full[w];
    ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    return {ovf, co, sum[15:0]};
  endfunction

  task automatic push(input int d, input logic [15:0] a, input logic [15:0] b,
                      input logic ci, input logic op, input logic [15:0] sum,
                      input logic co, input logic ovf);
    beat_t bt;
    bt.a = a; bt.b = b; bt.ci = ci; bt.op = op;
    bt.sum = sum; bt.co = co; bt.ovf = ovf;
    txq[d].push_back(bt);
    pushed[d]++;
  endtask

  task automatic push_rand(input int d);
    logic [15:0] a, b;
    logic        ci, op;
    logic [17:0] r;
    a  = 16'($urandom);
    b  = 16'($urandom);
    ci = 1'($urandom_range(0, 1));
    op = 1'($urandom_range(0, 1));
    r  = ref_result(W_D[d], a, b, ci, op);
    push(d, a, b, ci, op, r[15:0], r[16], r[17]);
  endtask

  function automatic bit busy();
    bit b;
    b = 1'b0;
    for (int d = 0; d < 3; d++) begin
      if (txq[d].size() > 0) b = 1'b1;
      for (int s = 0; s < S_D[d]; s++) if (pv[d][s]) b = 1'b1;
    end
    return b;
  endfunction

  // One clock cycle: drive from the queues, check outputs, advance the model.
  task automatic step();
    logic adv;
    int   last;
    for (int d = 0; d < 3; d++) begin
      if (txq[d].size() > 0) begin
        ivld[d] = 1'b1;
        a_i[d]  = txq[d][0].a;
        b_i[d]  = txq[d][0].b;
        ci_i[d] = txq[d][0].ci;
        op_i[d] = txq[d][0].op;
      end else begin
        ivld[d] = 1'b0;
        a_i[d]  = '0;
        b_i[d]  = '0;
        ci_i[d] = 1'b0;
        op_i[d] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 3; d++) begin
      last = S_D[d] - 1;
      adv  = !pv[d][last] || ordy[d];
      check($sformatf("in_ready.d%0d.c%0d", d, cyc), 32'(irdy_o[d]), 32'(adv));
      check($sformatf("out_valid.d%0d.c%0d", d, cyc), 32'(ov_o[d]), 32'(pv[d][last]));
      if (pv[d][last]) begin
        check($sformatf("sum.d%0d.c%0d", d, cyc), 32'(sum_o[d]), 32'(pipe[d][last].sum));
        check($sformatf("co.d%0d.c%0d", d, cyc), 32'(co_o[d]), 32'(pipe[d][last].co));
        check($sformatf("ovf.d%0d.c%0d", d, cyc), 32'(ovf_o[d]), 32'(pipe[d][last].ovf));
        if (ordy[d]) popped[d]++;
      end
      if (adv) begin
        for (int s = last; s > 0; s--) begin
          pipe[d][s] = pipe[d][s-1];
          pv[d][s]   = pv[d][s-1];
        end
        pv[d][0] = ivld[d];
        if (ivld[d]) pipe[d][0] = txq[d].pop_front();
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (busy() && guard < 200) begin
      step();
      guard++;
    end
    for (int d = 0; d < 3; d++)
      check($sformatf("%s.count.d%0d", tag, d), 32'(popped[d]), 32'(pushed[d]));
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      txq[d].delete();
      for (int s = 0; s < 4; s++) pv[d][s] = 1'b0;
      popped[d] = 0;
      pushed[d] = 0;
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      ivld[d] = 1'b0; ordy[d] = 1'b1; a_i[d] = '0; b_i[d] = '0;
      ci_i[d] = 1'b0; op_i[d] = 1'b0;
    end
    clear_model();

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    check("rst.out_valid", 32'(ov16), 32'd0);
    check("rst.out_sum", 32'(sum16), 32'd0);
    check("rst.out_co", 32'(co16), 32'd0);
    check("rst.out_ovf", 32'(ovf16), 32'd0);
    check("rst.in_ready", 32'(irdy16), 32'd1);
    check("rst.out_valid.d8", 32'(ov8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed ADD/SUB with carries across chunks, wrap and overflow.
    push(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    push(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    push(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    push(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    push(0, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    push(0, 16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0);
    drain("directed");

    // Single-stage configuration: latency 1.
    push(2, 16'h0080, 16'h0080, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1);
    push(2, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1);
    push(2, 16'h0010, 16'h0020, 1'b0, 1'b1, 16'h00F0, 1'b0, 1'b0);
    drain("w8s1");

    // Random back-to-back streams with backpressure in cycles 6..9.
    clear_model();
    for (int i = 0; i < 8; i++) begin
      push_rand(0);
      push_rand(1);
    end
    for (int c = 0; c < 60 && busy(); c++) begin
      ordy[0] = !(c >= 6 && c <= 9);
      ordy[1] = !(c >= 6 && c <= 9);
      step();
    end
    ordy[0] = 1'b1;
    ordy[1] = 1'b1;
    check("stream.count.d16", 32'(popped[0]), 32'd8);
    check("stream.count.d12", 32'(popped[1]), 32'd8);

    // Reset with beats in flight.
    clear_model();
    push(0, 16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
    push(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
    push(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("midrst.pre_valid", 32'(ov16), 32'(pv[0][3]));
    #2 rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 32'(ov16), 32'd0);
    check("midrst.out_sum", 32'(sum16), 32'd0);
    check("midrst.out_co", 32'(co16), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 8; i++) step();
    push(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    drain("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
